conv_tile_scheduler: RTL and testbench

- Top-level sequencer for the image input buffer and PE array.
- Walks the loop nest layer → output channel → input channel.
- For each input-channel tile it:
  - requests a DMA image load,
  - drives the buffer's state, layer, ic and oc controls,
  - counts row-done pulses,
  - waits for the buffer's send-to-DMA flag on the last input channel before advancing the output channel.
- Sits between the PS-side control registers and the input buffer / AXI DMA MM2S channel.

---
 rtl/accel_pkg.sv | 33 +++
 rtl/loop_counter_3d.sv | 69 ++++++
 rtl/conv_tile_scheduler.sv | 158 +++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants and encodings for the image-buffer / PE-array sequencer.
// Holds the externally visible state codes, tile geometry and per-layer loop bounds.
package accel_pkg;

  typedef enum logic [1:0] {
    OST_IDLE        = 2'd0,
    OST_IMAGES_LOAD = 2'd1,
    OST_SEND_DATA   = 2'd2
  } ostate_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_COMPUTE,
    S_WAIT_SEND,
    S_ADVANCE
  } fsm_e;

  localparam int TILE_BYTES       = 2304;
  localparam int ROWS_DEF         = 16;
  localparam int IC_L0_DEF        = 1;
  localparam int IC_LN            = 64;
  localparam int OC_DEF           = 64;
  localparam int NUM_LAYERS_DEF   = 3;
  localparam int SEND_TIMEOUT_DEF = 1024;

  // Last input-channel index of a layer: layer 0 is the image input, deeper layers are 64 wide.
  function automatic logic [5:0] ic_max(input logic [1:0] layer, input int ic_l0);
    return (layer == 2'd0) ? 6'(ic_l0 - 1) : 6'(IC_LN - 1);
  endfunction

endpackage

// File: rtl/loop_counter_3d.sv
// Nested layer -> oc -> ic counter; one increment steps ic and carries into oc and layer.
// Exposes the next-state values so the caller can latch them on the same edge.
module loop_counter_3d
  import accel_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int IC_L0      = IC_L0_DEF,
  parameter int OC_MAX     = OC_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [1:0] layer_d_o,
  output logic [5:0] oc_d_o,
  output logic [5:0] ic_d_o,
  output logic       last_ic_o,
  output logic       last_oc_o,
  output logic       last_layer_o
);

  logic [1:0] layer_q, layer_d;
  logic [5:0] oc_q, oc_d;
  logic [5:0] ic_q, ic_d;

  assign last_ic_o    = (ic_q == ic_max(layer_q, IC_L0));
  assign last_oc_o    = (oc_q == 6'(OC_MAX - 1));
  assign last_layer_o = (layer_q == 2'(NUM_LAYERS - 1));

  always_comb begin
    layer_d = layer_q;
    oc_d    = oc_q;
    ic_d    = ic_q;
    if (clr_i) begin
      layer_d = 2'd0;
      oc_d    = 6'd0;
      ic_d    = 6'd0;
    end else if (inc_i) begin
      if (!last_ic_o) begin
        ic_d = ic_q + 6'd1;
      end else begin
        ic_d = 6'd0;
        if (!last_oc_o) begin
          oc_d = oc_q + 6'd1;
        end else begin
          oc_d    = 6'd0;
          layer_d = last_layer_o ? 2'd0 : layer_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      layer_q <= 2'd0;
      oc_q    <= 6'd0;
      ic_q    <= 6'd0;
    end else begin
      layer_q <= layer_d;
      oc_q    <= oc_d;
      ic_q    <= ic_d;
    end
  end

  assign layer_d_o = layer_d;
  assign oc_d_o    = oc_d;
  assign ic_d_o    = ic_d;

endmodule

// File: rtl/conv_tile_scheduler.sv
// Tile sequencer: per input-channel tile, request a DMA load, count computed rows,
// and on the last ic of an oc wait for the buffer's send flag before advancing.
module conv_tile_scheduler
  import accel_pkg::*;
#(
  parameter int NUM_LAYERS   = NUM_LAYERS_DEF,
  parameter int ROWS         = ROWS_DEF,
  parameter int IC_L0        = IC_L0_DEF,
  parameter int OC_MAX       = OC_DEF,
  parameter int SEND_TIMEOUT = SEND_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_dma_req,
  input  logic       i_load_done,
  input  logic       i_img_row_done,
  input  logic       i_send_flg,
  output logic [1:0] o_state,
  output logic [1:0] o_current_layer,
  output logic [5:0] o_current_ic,
  output logic [5:0] o_current_oc,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  fsm_e        state_q;
  logic [4:0]  row_q;
  logic [10:0] tmo_q;
  logic [1:0]  layer_nxt;
  logic [5:0]  oc_nxt, ic_nxt;
  logic        last_ic, last_oc, last_layer;
  logic        row_final, all_last, go_req, cnt_clr, cnt_inc;

  assign row_final = i_img_row_done && (row_q == 5'(ROWS - 1));
  assign all_last  = last_ic && last_oc && last_layer;
  assign cnt_clr   = !i_abort && (state_q == S_IDLE) && i_start;
  assign cnt_inc   = !i_abort && (((state_q == S_COMPUTE) && row_final && !last_ic) ||
                                  (state_q == S_ADVANCE));
  assign go_req    = cnt_clr || (cnt_inc && !((state_q == S_ADVANCE) && all_last));

  loop_counter_3d #(
    .NUM_LAYERS (NUM_LAYERS),
    .IC_L0      (IC_L0),
    .OC_MAX     (OC_MAX)
  ) u_cnt (
    .clk          (clk),
    .rstn         (rstn),
    .clr_i        (cnt_clr),
    .inc_i        (cnt_inc),
    .layer_d_o    (layer_nxt),
    .oc_d_o       (oc_nxt),
    .ic_d_o       (ic_nxt),
    .last_ic_o    (last_ic),
    .last_oc_o    (last_oc),
    .last_layer_o (last_layer)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      row_q           <= 5'd0;
      tmo_q           <= 11'd0;
      o_dma_req       <= 1'b0;
      o_state         <= OST_IDLE;
      o_current_layer <= 2'd0;
      o_current_ic    <= 6'd0;
      o_current_oc    <= 6'd0;
      o_valid         <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_dma_req <= 1'b0;
      o_done    <= 1'b0;
      if (i_abort) begin
        state_q <= S_IDLE;
        o_state <= OST_IDLE;
        o_valid <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              row_q <= 5'd0;
              tmo_q <= 11'd0;
              o_err <= 1'b0;
            end
          end
          S_REQ: begin
            state_q <= S_LOAD;
            o_valid <= 1'b1;
          end
          S_LOAD: begin
            if (i_load_done) begin
              state_q <= S_COMPUTE;
              o_state <= OST_SEND_DATA;
              row_q   <= 5'd0;
            end
          end
          S_COMPUTE: begin
            if (i_img_row_done) begin
              row_q <= row_q + 5'd1;
              // A send flag coinciding with the final row skips the wait entirely.
              if (row_final && last_ic) begin
                if (i_send_flg) begin
                  state_q <= S_ADVANCE;
                  o_valid <= 1'b0;
                end else begin
                  state_q <= S_WAIT_SEND;
                  tmo_q   <= 11'd0;
                end
              end
            end
          end
          S_WAIT_SEND: begin
            if (i_send_flg) begin
              state_q <= S_ADVANCE;
              o_valid <= 1'b0;
            end else if (tmo_q == 11'(SEND_TIMEOUT - 1)) begin
              state_q <= S_IDLE;
              o_state <= OST_IDLE;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_err   <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 11'd1;
            end
          end
          S_ADVANCE: begin
            if (all_last) begin
              state_q <= S_IDLE;
              o_state <= OST_IDLE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
        // Displayed loop indices only move when a new tile is requested.
        if (go_req) begin
          state_q         <= S_REQ;
          o_dma_req       <= 1'b1;
          o_state         <= OST_IMAGES_LOAD;
          o_valid         <= 1'b0;
          o_busy          <= 1'b1;
          o_current_layer <= layer_nxt;
          o_current_oc    <= oc_nxt;
          o_current_ic    <= ic_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed/randomized bench: a nested-loop tile list is the reference for every transaction;
// handshake pulses are driven with random gaps, stray pulses and coincident send flags.
module tb_conv_tile_scheduler;

  localparam int NL   = 2;
  localparam int ROWS = 2;
  localparam int ICL0 = 1;
  localparam int OCM  = 2;
  localparam int STO  = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_start = 1'b0, i_abort = 1'b0;
  logic       i_load_done = 1'b0, i_img_row_done = 1'b0, i_send_flg = 1'b0;
  logic       o_dma_req, o_valid, o_busy, o_done, o_err;
  logic [1:0] o_state, o_current_layer;
  logic [5:0] o_current_ic, o_current_oc;

  int tests = 0;
  int fails = 0;
  int dma_cnt = 0;

  typedef struct {
    int l;
    int oc;
    int ic;
    bit last_ic;
    bit final_t;
  } tile_t;
  tile_t model_q[$];

  conv_tile_scheduler #(
    .NUM_LAYERS (NL),
    .ROWS (ROWS),
    .IC_L0 (ICL0),
    .OC_MAX (OCM),
    .SEND_TIMEOUT (STO)
  ) dut (
    .clk (clk),
    .rstn (rstn),
    .i_start (i_start),
    .i_abort (i_abort),
    .o_dma_req (o_dma_req),
    .i_load_done (i_load_done),
    .i_img_row_done (i_img_row_done),
    .i_send_flg (i_send_flg),
    .o_state (o_state),
    .o_current_layer (o_current_layer),
    .o_current_ic (o_current_ic),
    .o_current_oc (o_current_oc),
    .o_valid (o_valid),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_req(input int exp_wait);
    int w = 0;
    while (!o_dma_req && w < 20) begin
      tick();
      w++;
    end
    check("req_latency", w, exp_wait);
    if (o_dma_req) dma_cnt++;
  endtask

  // mode: 0 normal, 1 stop in WAIT_SEND (timeout), 2 abort while in LOAD
  task automatic do_tile(input tile_t t, input int exp_wait, input int mode,
                         input bit strays, input bit coincide, input bit start_poke);
    int gap;
    wait_req(exp_wait);
    $display("[TB] tile layer=%0d oc=%0d ic=%0d mode=%0d strays=%0d coincide=%0d",
             t.l, t.oc, t.ic, mode, strays, coincide);
    check("req_layer", o_current_layer, t.l);
    check("req_oc", o_current_oc, t.oc);
    check("req_ic", o_current_ic, t.ic);
    check("req_state", o_state, 1);
    check("req_valid", o_valid, 0);
    check("req_busy", o_busy, 1);
    tick();
    check("load_state", o_state, 1);
    check("req_one_cycle", o_dma_req, 0);
    check("load_valid", o_valid, 1);
    if (mode == 2) begin
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_valid", o_valid, 0);
      check("abort_state", o_state, 0);
      check("abort_hold_layer", o_current_layer, t.l);
      check("abort_hold_oc", o_current_oc, t.oc);
      check("abort_hold_ic", o_current_ic, t.ic);
      return;
    end
    if (start_poke) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("busy_start_state", o_state, 1);
      check("busy_start_req", o_dma_req, 0);
      check("busy_start_ic", o_current_ic, t.ic);
    end
    gap = strays ? $urandom_range(1, 2) : $urandom_range(0, 2);
    repeat (gap) begin
      i_img_row_done = strays;
      i_send_flg = strays;
      tick();
      i_img_row_done = 1'b0;
      i_send_flg = 1'b0;
      check("load_hold", o_state, 1);
    end
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    check("compute_state", o_state, 2);
    check("compute_valid", o_valid, 1);
    if (strays) begin
      i_load_done = 1'b1;
      tick();
      i_load_done = 1'b0;
      check("stray_load_done", o_state, 2);
    end
    for (int r = 0; r < ROWS; r++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i_send_flg = strays;
        tick();
        i_send_flg = 1'b0;
      end
      i_img_row_done = 1'b1;
      if (r == ROWS - 1 && coincide && t.last_ic) i_send_flg = 1'b1;
      tick();
      i_img_row_done = 1'b0;
      i_send_flg = 1'b0;
      if (r < ROWS - 1) begin
        check("row_state", o_state, 2);
        check("row_no_req", o_dma_req, 0);
      end
    end
    if (!t.last_ic) return;
    if (!coincide) begin
      check("wait_state", o_state, 2);
      check("wait_valid", o_valid, 1);
      check("wait_no_req", o_dma_req, 0);
      if (mode == 1) return;
      repeat ($urandom_range(0, 4)) tick();
      check("wait_hold", o_state, 2);
      i_send_flg = 1'b1;
      tick();
      i_send_flg = 1'b0;
    end
    check("adv_valid", o_valid, 0);
    check("adv_busy", o_busy, 1);
    check("adv_done", o_done, 0);
    check("adv_err", o_err, 0);
    if (t.final_t) begin
      tick();
      check("done_pulse", o_done, 1);
      check("done_busy", o_busy, 0);
      check("done_state", o_state, 0);
      tick();
      check("done_one_cycle", o_done, 0);
    end
  endtask

  initial begin
    int ew;
    int nic;
    bit strays;
    for (int l = 0; l < NL; l++) begin
      nic = (l == 0) ? ICL0 : 64;
      for (int oc = 0; oc < OCM; oc++)
        for (int ic = 0; ic < nic; ic++)
          model_q.push_back('{l, oc, ic, ic == nic - 1,
                              (l == NL - 1) && (oc == OCM - 1) && (ic == nic - 1)});
    end

    repeat (2) @(negedge clk);
    check("rst_state", o_state, 0);
    check("rst_req", o_dma_req, 0);
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_fields", {o_current_layer, o_current_oc, o_current_ic}, 0);
    rstn = 1'b1;
    tick();

    i_load_done = 1'b1;
    i_img_row_done = 1'b1;
    i_send_flg = 1'b1;
    tick();
    i_load_done = 1'b0;
    i_img_row_done = 1'b0;
    i_send_flg = 1'b0;
    check("idle_stray_busy", o_busy, 0);

    // Send-flag timeout
    pulse_start();
    do_tile(model_q[0], 0, 1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= STO; k++) begin
      tick();
      if (k == STO - 1) begin
        check("tmo_early_err", o_err, 0);
        check("tmo_early_busy", o_busy, 1);
      end
    end
    check("tmo_err", o_err, 1);
    check("tmo_busy", o_busy, 0);
    check("tmo_state", o_state, 0);
    repeat (3) tick();
    check("tmo_err_sticky", o_err, 1);

    // Restart clears the error; abort the third tile while it loads
    pulse_start();
    check("start_clears_err", o_err, 0);
    do_tile(model_q[0], 0, 0, 1'b0, 1'b0, 1'b0);
    do_tile(model_q[1], 1, 0, 1'b0, 1'b1, 1'b0);
    do_tile(model_q[2], 1, 2, 1'b0, 1'b0, 1'b0);
    tick();
    check("abort_idle_busy", o_busy, 0);

    // Full run, restarting from layer 0 / oc 0 / ic 0
    dma_cnt = 0;
    pulse_start();
    ew = 0;
    for (int i = 0; i < model_q.size(); i++) begin
      strays = (i == 5) || ($urandom_range(0, 3) == 0);
      do_tile(model_q[i], ew, 0, strays, 1'($urandom_range(0, 1)), i == 5);
      ew = model_q[i].last_ic ? 1 : 0;
    end
    check("dma_req_count", dma_cnt, model_q.size());

    // Asynchronous reset in the middle of COMPUTE
    pulse_start();
    tick();
    i_load_done = 1'b1;
    tick();
    i_load_done = 1'b0;
    check("pre_reset_state", o_state, 2);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_state", o_state, 0);
    check("async_rst_busy", o_busy, 0);
    check("async_rst_valid", o_valid, 0);
    check("async_rst_req", o_dma_req, 0);
    #20 rstn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
